// File: rtl/audio_clk_mux_pkg.sv
// Shared types and constants for the audio master-clock mux sequencer.
package audio_clk_mux_pkg;

   // Sequencer states; the gate is open only in RUN.
   typedef enum logic [2:0] {
      HALT     = 3'd0,
      RUN      = 3'd1,
      GATE_OFF = 3'd2,
      DRAIN    = 3'd3,
      SETTLE   = 3'd4
   } state_t;

   // Mux select encoding for the two audio PLL families.
   localparam logic SRC_441 = 1'b0;
   localparam logic SRC_48  = 1'b1;

   // The source that is not the given one.
   function automatic logic other_src(input logic src);
      return (src == SRC_441) ? SRC_48 : SRC_441;
   endfunction

   // Counter width able to hold the larger of the two reload values.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/audio_clk_mux_ctrl_if.sv
// Control/status bundle between the register block, the sequencer and the mux cell.
interface audio_clk_mux_ctrl_if;
   logic sel_req_in;
   logic lock0_in;
   logic lock1_in;
   logic clk_sel;
   logic clk_en;
   logic busy;
   logic switch_done;
   logic src_lost;

   // master: whoever issues requests and lock flags and watches status.
   modport master (
      output sel_req_in, lock0_in, lock1_in,
      input  clk_sel, clk_en, busy, switch_done, src_lost
   );

   // slave: the sequencer itself.
   modport slave (
      input  sel_req_in, lock0_in, lock1_in,
      output clk_sel, clk_en, busy, switch_done, src_lost
   );
endinterface

// File: rtl/syncro2_2.sv
// Dual two-flop synchroniser for slow asynchronous level signals.
module syncro2_2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] d,
   output logic [1:0] q
);

   logic [1:0] meta_reg;
   logic [1:0] sync_reg;

   // Two flop stages per bit; both clear on reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/audio_clk_mux_ctrl.sv
// Glitch-free audio clock mux sequencer: gate off, drain, switch, settle, gate on.
// Optional build macro AUDIO_CLK_FAILOVER_EN: when the requested PLL is unlocked
// and the other one is locked, the other PLL becomes the switch target.
module audio_clk_mux_ctrl
   import audio_clk_mux_pkg::*;
#(
   parameter int DRAIN_CYCLES  = 4,
   parameter int SETTLE_CYCLES = 8
) (
   input  logic                 clk,
   input  logic                 reset_n,
   audio_clk_mux_ctrl_if.slave  bus
);

   localparam int CW = cnt_width(DRAIN_CYCLES, SETTLE_CYCLES);
   localparam logic [CW-1:0] DRAIN_LOAD  = CW'(DRAIN_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

   logic [1:0] lock_s;
   logic [1:0] sel_q;
   logic       sel_s;
   logic       sync_unused;
   logic       target;

   syncro2_2 u_sync_lock (
      .clk     (clk),
      .reset_n (reset_n),
      .d       ({bus.lock1_in, bus.lock0_in}),
      .q       (lock_s)
   );

   syncro2_2 u_sync_sel (
      .clk     (clk),
      .reset_n (reset_n),
      .d       ({1'b0, bus.sel_req_in}),
      .q       (sel_q)
   );

   assign sel_s       = sel_q[0];
   assign sync_unused = sel_q[1];

`ifdef AUDIO_CLK_FAILOVER_EN
   localparam bit FAILOVER = 1'b1;
   // Fall back to the other PLL when the requested one is down and the other is up.
   assign target = (!lock_s[sel_s] && lock_s[other_src(sel_s)]) ? other_src(sel_s) : sel_s;
`else
   localparam bit FAILOVER = 1'b0;
   assign target = sel_s;
`endif

   state_t        state_reg, state_next;
   logic [CW-1:0] count_reg, count_next;
   logic          sel_reg, sel_next;
   logic          lost_reg, lost_next;
   logic          en_reg, en_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;

   // State, counter, select and registered status outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= HALT;
         count_reg <= '0;
         sel_reg   <= SRC_441;
         lost_reg  <= 1'b0;
         en_reg    <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         count_reg <= count_next;
         sel_reg   <= sel_next;
         lost_reg  <= lost_next;
         en_reg    <= en_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   // Sequencing decisions; the select only moves on the DRAIN->SETTLE or HALT->SETTLE step.
   always_comb begin
      state_next = state_reg;
      count_next = count_reg;
      sel_next   = sel_reg;
      lost_next  = lost_reg;
      case (state_reg)
         HALT: begin
            if (lock_s[target]) begin
               sel_next   = target;
               count_next = SETTLE_LOAD;
               state_next = SETTLE;
            end
         end
         RUN: begin
            // A change of target wins over a lock loss on the running source.
            if (target != sel_reg) begin
               state_next = GATE_OFF;
               if (FAILOVER && !lock_s[sel_reg]) begin
                  lost_next = 1'b1;
               end
            end else if (!lock_s[sel_reg]) begin
               lost_next  = 1'b1;
               state_next = HALT;
            end
         end
         GATE_OFF: begin
            count_next = DRAIN_LOAD;
            state_next = DRAIN;
         end
         DRAIN: begin
            if (count_reg != '0) begin
               count_next = count_reg - 1'b1;
            end else if (lock_s[target]) begin
               // Latest request wins: target is sampled only here.
               sel_next   = target;
               count_next = SETTLE_LOAD;
               state_next = SETTLE;
            end else begin
               lost_next  = 1'b1;
               state_next = HALT;
            end
         end
         SETTLE: begin
            if (!lock_s[sel_reg]) begin
               lost_next  = 1'b1;
               state_next = HALT;
            end else if (count_reg != '0) begin
               count_next = count_reg - 1'b1;
            end else begin
               lost_next  = 1'b0;
               state_next = RUN;
            end
         end
         default: begin
            state_next = HALT;
         end
      endcase
   end

   // Status outputs derived from the upcoming state so they register with it.
   always_comb begin
      en_next   = (state_next == RUN);
      busy_next = (state_next == GATE_OFF) || (state_next == DRAIN) || (state_next == SETTLE);
      done_next = (state_reg == SETTLE) && (state_next == RUN);
   end

   assign bus.clk_sel     = sel_reg;
   assign bus.clk_en      = en_reg;
   assign bus.busy        = busy_reg;
   assign bus.switch_done = done_reg;
   assign bus.src_lost    = lost_reg;

endmodule

// File: tb/tb_audio_clk_mux_ctrl.sv
// Self-checking bench for audio_clk_mux_ctrl: expected event cycles come from the
// documented latencies (2-flop sync, +1 decision, drain, settle) and a source model.
module tb_audio_clk_mux_ctrl;

   localparam int D          = 4;
   localparam int S          = 8;
   localparam int SYNC       = 2;
   localparam int LAT_OFF    = SYNC + 1;          // request -> gate closed
   localparam int LAT_SEL    = LAT_OFF + D + 1;   // request -> select moves
   localparam int LAT_ON     = LAT_SEL + S;       // request -> gate open
   localparam int LAT_RELOCK = SYNC + 1 + S;      // lock/reset release from HALT -> gate open

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   logic cur;

   audio_clk_mux_ctrl_if bus ();

   audio_clk_mux_ctrl #(.DRAIN_CYCLES(D), .SETTLE_CYCLES(S)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitor on the falling edge: select moves, gate edges, done pulses, invariants.
   logic prev_sel = 1'b0;
   logic prev_en = 1'b0;
   int   sel_chg_cyc = -1000;
   int   done_cnt = 0;
   int   inv_viol = 0;

   always @(negedge clk) begin
      if (!reset_n) begin
         if (bus.clk_sel !== prev_sel) sel_chg_cyc = cyc;
      end else begin
         if (bus.clk_sel !== prev_sel) begin
            if (prev_en || bus.clk_en) begin
               inv_viol++;
               $display("invariant: clk_sel moved with gate open at cycle %0d", cyc);
            end
            sel_chg_cyc = cyc;
         end
         if (bus.clk_en && !prev_en && (cyc - sel_chg_cyc < S)) begin
            inv_viol++;
            $display("invariant: gate opened %0d cycles after select change", cyc - sel_chg_cyc);
         end
         if (bus.switch_done) done_cnt++;
      end
      prev_sel = bus.clk_sel;
      prev_en  = bus.clk_en;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_en(input logic level, input int budget, output int at);
      bit ok;
      ok = 1'b0;
      at = -1;
      for (int i = 0; i <= budget && !ok; i++) begin
         if (bus.clk_en === level) begin
            ok = 1'b1;
            at = cyc;
         end else begin
            tick(1);
         end
      end
   endtask

   task automatic set_lock(input logic idx, input logic v);
      if (idx) bus.lock1_in = v;
      else     bus.lock0_in = v;
   endtask

   task automatic test_reset();
      int r, at, d0;
      bus.sel_req_in = 1'b0;
      bus.lock0_in   = 1'b1;
      bus.lock1_in   = 1'($urandom % 2);
      tick(3);
      checks++;
      if ({bus.clk_sel, bus.clk_en, bus.busy, bus.switch_done, bus.src_lost} !== 5'b0)
         begin failures++; $display("FAIL reset_outputs: got %b expected 00000",
            {bus.clk_sel, bus.clk_en, bus.busy, bus.switch_done, bus.src_lost}); end
      r = cyc;
      d0 = done_cnt;
      reset_n = 1'b1;
      wait_en(1'b1, 40, at);
      $display("reset release at cycle %0d, gate open at %0d", r, at);
      checks++;
      if (at != r + LAT_RELOCK) begin failures++;
         $display("FAIL reset_en_rise: got %0d expected %0d", at, r + LAT_RELOCK); end
      checks++;
      if (bus.clk_sel !== 1'b0) begin failures++;
         $display("FAIL reset_clk_sel: got %b expected 0", bus.clk_sel); end
      tick(3);
      checks++;
      if (done_cnt - d0 != 1) begin failures++;
         $display("FAIL reset_done_count: got %0d expected 1", done_cnt - d0); end
      checks++;
      if ({bus.busy, bus.src_lost} !== 2'b00) begin failures++;
         $display("FAIL reset_status: got %b expected 00", {bus.busy, bus.src_lost}); end
      cur = 1'b0;
   endtask

   task automatic test_switch();
      int e, at, d0, k, n;
      logic t;
      set_lock(1'b0, 1'b1);
      set_lock(1'b1, 1'b1);
      tick(4);
      n = $urandom_range(3, 5);
      for (int it = 0; it < n; it++) begin
         tick($urandom_range(1, 6));
         t  = ~cur;
         e  = cyc;
         d0 = done_cnt;
         bus.sel_req_in = t;
         k = $urandom_range(LAT_OFF, LAT_ON - 1);
         tick(k);
         checks++;
         if ({bus.busy, bus.clk_en} !== 2'b10) begin failures++;
            $display("FAIL switch_busy: got busy/en %b at +%0d expected 10", {bus.busy, bus.clk_en}, k); end
         wait_en(1'b1, 40, at);
         $display("switch %0d->%0d requested at cycle %0d, gate open at %0d", cur, t, e, at);
         checks++;
         if (sel_chg_cyc != e + LAT_SEL) begin failures++;
            $display("FAIL switch_sel_time: got %0d expected %0d", sel_chg_cyc, e + LAT_SEL); end
         checks++;
         if (at != e + LAT_ON || bus.clk_sel !== t) begin failures++;
            $display("FAIL switch_en_rise: got cycle %0d sel %b expected cycle %0d sel %b",
               at, bus.clk_sel, e + LAT_ON, t); end
         tick(1);
         checks++;
         if (done_cnt - d0 != 1 || bus.src_lost !== 1'b0 || bus.busy !== 1'b0) begin failures++;
            $display("FAIL switch_done: got pulses %0d lost %b busy %b expected 1 0 0",
               done_cnt - d0, bus.src_lost, bus.busy); end
         cur = t;
      end
   endtask

   // Switch toward an unlocked PLL, then let it lock.
   task automatic test_lost_lock_switch();
      int e, f, at, a0, d0;
      logic t;
      t = ~cur;
      set_lock(t, 1'b0);
      tick($urandom_range(3, 5));
      e = cyc;
      bus.sel_req_in = t;
`ifdef AUDIO_CLK_FAILOVER_EN
      tick(LAT_ON);
      checks++;
      if ({bus.clk_en, bus.clk_sel, bus.src_lost, bus.busy} !== {1'b1, cur, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL failover_hold: got en/sel/lost/busy %b expected %b",
            {bus.clk_en, bus.clk_sel, bus.src_lost, bus.busy}, {1'b1, cur, 1'b0, 1'b0}); end
      f = cyc;
      set_lock(t, 1'b1);
      wait_en(1'b0, 20, a0);
      checks++;
      if (a0 != f + LAT_OFF) begin failures++;
         $display("FAIL failover_relock_off: got %0d expected %0d", a0, f + LAT_OFF); end
      wait_en(1'b1, 40, at);
      $display("relock of %0d at cycle %0d, gate open at %0d", t, f, at);
      checks++;
      if (at != f + LAT_ON || bus.clk_sel !== t) begin failures++;
         $display("FAIL failover_relock_on: got cycle %0d sel %b expected cycle %0d sel %b",
            at, bus.clk_sel, f + LAT_ON, t); end
`else
      wait_en(1'b0, 20, a0);
      checks++;
      if (a0 != e + LAT_OFF) begin failures++;
         $display("FAIL lostsw_en_fall: got %0d expected %0d", a0, e + LAT_OFF); end
      tick(LAT_SEL + 1 - LAT_OFF);
      checks++;
      if ({bus.clk_en, bus.busy, bus.src_lost, bus.clk_sel} !== {1'b0, 1'b0, 1'b1, cur}) begin
         failures++;
         $display("FAIL lostsw_halt: got en/busy/lost/sel %b expected %b",
            {bus.clk_en, bus.busy, bus.src_lost, bus.clk_sel}, {1'b0, 1'b0, 1'b1, cur}); end
      tick($urandom_range(2, 6));
      f  = cyc;
      d0 = done_cnt;
      set_lock(t, 1'b1);
      wait_en(1'b1, 40, at);
      $display("relock of %0d at cycle %0d, gate open at %0d", t, f, at);
      checks++;
      if (at != f + LAT_RELOCK || bus.clk_sel !== t) begin failures++;
         $display("FAIL lostsw_relock: got cycle %0d sel %b expected cycle %0d sel %b",
            at, bus.clk_sel, f + LAT_RELOCK, t); end
      tick(1);
      checks++;
      if (bus.src_lost !== 1'b0 || done_cnt - d0 != 1) begin failures++;
         $display("FAIL lostsw_clear: got lost %b pulses %0d expected 0 1", bus.src_lost, done_cnt - d0); end
`endif
      cur = t;
      tick(2);
   endtask

   // Lock loss on the running source, then relock.
   task automatic test_lock_drop();
      int e, f, at, a0, d0;
      logic o;
      o = 1'($urandom % 2);
      set_lock(~cur, o);
      tick($urandom_range(3, 5));
      e = cyc;
      set_lock(cur, 1'b0);
`ifdef AUDIO_CLK_FAILOVER_EN
      if (o) begin
         tick(LAT_OFF + 1);
         checks++;
         if ({bus.clk_en, bus.busy, bus.src_lost} !== 3'b011) begin failures++;
            $display("FAIL failover_drop: got en/busy/lost %b expected 011",
               {bus.clk_en, bus.busy, bus.src_lost}); end
         wait_en(1'b1, 40, at);
         checks++;
         if (at != e + LAT_ON || bus.clk_sel !== ~cur || bus.src_lost !== 1'b0) begin failures++;
            $display("FAIL failover_switch: got cycle %0d sel %b lost %b expected cycle %0d sel %b lost 0",
               at, bus.clk_sel, bus.src_lost, e + LAT_ON, ~cur); end
         f = cyc;
         set_lock(cur, 1'b1);
         wait_en(1'b0, 20, a0);
         wait_en(1'b1, 40, at);
         $display("failover back to %0d relocked at cycle %0d, gate open at %0d", cur, f, at);
         checks++;
         if (a0 != f + LAT_OFF || at != f + LAT_ON || bus.clk_sel !== cur) begin failures++;
            $display("FAIL failover_return: got off %0d on %0d sel %b expected off %0d on %0d sel %b",
               a0, at, bus.clk_sel, f + LAT_OFF, f + LAT_ON, cur); end
         set_lock(~cur, 1'b1);
         tick(2);
         return;
      end
`endif
      tick(LAT_OFF + 1);
      checks++;
      if ({bus.clk_en, bus.busy, bus.src_lost, bus.clk_sel} !== {1'b0, 1'b0, 1'b1, cur}) begin
         failures++;
         $display("FAIL drop_halt: got en/busy/lost/sel %b expected %b",
            {bus.clk_en, bus.busy, bus.src_lost, bus.clk_sel}, {1'b0, 1'b0, 1'b1, cur}); end
      tick($urandom_range(1, 6));
      f  = cyc;
      d0 = done_cnt;
      set_lock(cur, 1'b1);
      wait_en(1'b1, 40, at);
      $display("lock drop on %0d at cycle %0d, relock at %0d, gate open at %0d", cur, e, f, at);
      checks++;
      if (at != f + LAT_RELOCK || bus.clk_sel !== cur) begin failures++;
         $display("FAIL drop_relock: got cycle %0d sel %b expected cycle %0d sel %b",
            at, bus.clk_sel, f + LAT_RELOCK, cur); end
      tick(1);
      checks++;
      if (bus.src_lost !== 1'b0 || done_cnt - d0 != 1) begin failures++;
         $display("FAIL drop_clear: got lost %b pulses %0d expected 0 1", bus.src_lost, done_cnt - d0); end
      set_lock(~cur, 1'b1);
      tick(2);
   endtask

   // Request goes away and comes back while draining: full sequence, original source.
   task automatic test_drain_toggle();
      int e, at, a0, d0, sc0, tb;
      logic t;
      t   = ~cur;
      e   = cyc;
      d0  = done_cnt;
      sc0 = sel_chg_cyc;
      bus.sel_req_in = t;
      tb = $urandom_range(2, 5);
      tick(tb);
      bus.sel_req_in = cur;
      wait_en(1'b0, 20, a0);
      wait_en(1'b1, 40, at);
      $display("toggle %0d->%0d->%0d at cycle %0d (+%0d), gate open at %0d", cur, t, cur, e, tb, at);
      checks++;
      if (a0 != e + LAT_OFF || at != e + LAT_ON) begin failures++;
         $display("FAIL toggle_timing: got off %0d on %0d expected off %0d on %0d",
            a0, at, e + LAT_OFF, e + LAT_ON); end
      checks++;
      if (bus.clk_sel !== cur || sel_chg_cyc != sc0) begin failures++;
         $display("FAIL toggle_sel: got sel %b last move %0d expected sel %b last move %0d",
            bus.clk_sel, sel_chg_cyc, cur, sc0); end
      tick(1);
      checks++;
      if (done_cnt - d0 != 1) begin failures++;
         $display("FAIL toggle_done_count: got %0d expected 1", done_cnt - d0); end
      tick(2);
   endtask

   // Request changes back during SETTLE: first switch completes, then a second one runs.
   task automatic test_back_to_back();
      int e, at1, at2, a0, d0;
      logic t;
      t  = ~cur;
      e  = cyc;
      d0 = done_cnt;
      bus.sel_req_in = t;
      tick(LAT_SEL + $urandom_range(0, 4));
      bus.sel_req_in = cur;
      wait_en(1'b1, 40, at1);
      checks++;
      if (at1 != e + LAT_ON || bus.clk_sel !== t) begin failures++;
         $display("FAIL b2b_first: got cycle %0d sel %b expected cycle %0d sel %b",
            at1, bus.clk_sel, e + LAT_ON, t); end
      wait_en(1'b0, 10, a0);
      checks++;
      if (a0 != e + LAT_ON + 1) begin failures++;
         $display("FAIL b2b_reopen_off: got %0d expected %0d", a0, e + LAT_ON + 1); end
      wait_en(1'b1, 40, at2);
      $display("back-to-back %0d->%0d->%0d from cycle %0d, gate open at %0d and %0d", cur, t, cur, e, at1, at2);
      checks++;
      if (at2 != a0 + D + 1 + S || bus.clk_sel !== cur) begin failures++;
         $display("FAIL b2b_second: got cycle %0d sel %b expected cycle %0d sel %b",
            at2, bus.clk_sel, a0 + D + 1 + S, cur); end
      tick(1);
      checks++;
      if (done_cnt - d0 != 2) begin failures++;
         $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
      tick(2);
   endtask

   // Reset asserted in SETTLE clears everything at once; the sequence reruns.
   task automatic test_reset_mid();
      int e, r, at, d0, k;
      logic t;
      t = ~cur;
      e = cyc;
      bus.sel_req_in = t;
      k = $urandom_range(1, 6);
      tick(LAT_SEL + k);
      checks++;
      if (bus.busy !== 1'b1) begin failures++;
         $display("FAIL midreset_in_settle: got busy %b expected 1", bus.busy); end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({bus.clk_sel, bus.clk_en, bus.busy, bus.switch_done, bus.src_lost} !== 5'b0) begin failures++;
         $display("FAIL midreset_async: got %b expected 00000",
            {bus.clk_sel, bus.clk_en, bus.busy, bus.switch_done, bus.src_lost}); end
      tick($urandom_range(1, 3));
      r  = cyc;
      d0 = done_cnt;
      reset_n = 1'b1;
      wait_en(1'b1, 40, at);
      $display("reset in settle at +%0d, released at cycle %0d, gate open at %0d", LAT_SEL + k - e + e, r, at);
      checks++;
      if (at != r + LAT_RELOCK || bus.clk_sel !== t) begin failures++;
         $display("FAIL midreset_rerun: got cycle %0d sel %b expected cycle %0d sel %b",
            at, bus.clk_sel, r + LAT_RELOCK, t); end
      tick(1);
      checks++;
      if (done_cnt - d0 != 1) begin failures++;
         $display("FAIL midreset_done_count: got %0d expected 1", done_cnt - d0); end
      cur = t;
   endtask

   task automatic test_invariants();
      checks++;
      if (inv_viol !== 0) begin failures++;
         $display("FAIL invariants: got %0d violations expected 0", inv_viol); end
   endtask

   initial begin
      bus.sel_req_in = 1'b0;
      bus.lock0_in   = 1'b1;
      bus.lock1_in   = 1'b0;
      #1 reset_n = 1'b0;
      test_reset();
      test_switch();
      test_lost_lock_switch();
      test_lock_drop();
      test_drain_toggle();
      test_back_to_back();
      test_reset_mid();
      test_invariants();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
